// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: glyph codes and scan FSM states.
package seg_pkg;

    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] BLANK_CODE = 5'd31;

    // Letter glyphs understood by the downstream decoder; 0-9 are plain digits.
    localparam logic [CODE_W-1:0] G_H = 5'd10;
    localparam logic [CODE_W-1:0] G_N = 5'd11;
    localparam logic [CODE_W-1:0] G_G = 5'd12;
    localparam logic [CODE_W-1:0] G_S = 5'd13;
    localparam logic [CODE_W-1:0] G_L = 5'd14;
    localparam logic [CODE_W-1:0] G_P = 5'd15;
    localparam logic [CODE_W-1:0] G_B = 5'd16;
    localparam logic [CODE_W-1:0] G_T = 5'd17;
    localparam logic [CODE_W-1:0] G_F = 5'd18;
    localparam logic [CODE_W-1:0] G_U = 5'd19;
    localparam logic [CODE_W-1:0] G_E = 5'd20;
    localparam logic [CODE_W-1:0] G_X = 5'd21;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timing for the digit scan: guard/drive FSM, slot counter, digit index and frame_done.
// Exposes next-cycle state/index so the owner can register outputs aligned with the slot.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_CYC  = 10,
    parameter int GUARD_CYC  = 2,
    localparam int CNT_W     = $clog2(DIGIT_CYC),
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output seg_state_e       state_nx_o,
    output logic [IDX_W-1:0] idx_nx_o,
    output logic             end_guard_o,
    output logic             end_slot_o,
    output logic             frame_done_o
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    seg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_done_q, frame_done_d;
    logic             end_guard, end_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        end_guard = (state_q == S_GUARD) && (cnt_q == GUARD_LAST);
        end_slot  = (cnt_q == CNT_LAST);
        state_d   = state_q;
        cnt_d     = end_slot ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        case (state_q)
            S_GUARD: if (end_guard) state_d = S_DRIVE;
            S_DRIVE: if (end_slot)  state_d = S_GUARD;
        endcase
        if (end_slot) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // Registered pulse lands on the last cycle of the last slot.
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    assign state_nx_o   = state_d;
    assign idx_nx_o     = idx_d;
    assign end_guard_o  = end_guard;
    assign end_slot_o   = end_slot;
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered frames and load/ready handshake.
// Optional per-digit blinking is compiled in with `define BLINK_EN.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CODE_W     = seg_pkg::CODE_W,
    parameter int CLK_HZ     = 50000000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD_CYC  = 2,
    parameter logic [CODE_W-1:0] BLANK_CODE = CODE_W'(seg_pkg::BLANK_CODE)
`ifdef BLINK_EN
    , parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUM_DIGITS*CODE_W-1:0] codes_in,
    input  logic [NUM_DIGITS-1:0]        dp_in,
    input  logic [NUM_DIGITS-1:0]        blank_in,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]        blink_in,
`endif
    output logic                         ready,
    output logic [CODE_W-1:0]            code_out,
    output logic [NUM_DIGITS-1:0]        an_n,
    output logic                         dp_n,
    output logic                         frame_done
);
    import seg_pkg::*;

    localparam int DIGIT_CYC = CLK_HZ / REFRESH_HZ;
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int CW_ALL    = NUM_DIGITS * CODE_W;

    seg_state_e       state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             end_guard, end_slot;

    seg_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_CYC  (DIGIT_CYC),
        .GUARD_CYC  (GUARD_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .state_nx_o   (state_nx),
        .idx_nx_o     (idx_nx),
        .end_guard_o  (end_guard),
        .end_slot_o   (end_slot),
        .frame_done_o (frame_done)
    );

    logic [CW_ALL-1:0]     pend_codes_q, pend_codes_d, disp_codes_q, disp_codes_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic                  pending_q, pending_d, ready_q, ready_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  swap, accept, dark;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_codes_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pending_q    <= 1'b0;
            disp_codes_q <= {NUM_DIGITS{BLANK_CODE}};
            disp_dp_q    <= '1;
            disp_blank_q <= '1;
            ready_q      <= 1'b1;
            code_q       <= BLANK_CODE;
            an_n_q       <= '1;
            dp_n_q       <= 1'b1;
        end else begin
            pend_codes_q <= pend_codes_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pending_q    <= pending_d;
            disp_codes_q <= disp_codes_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            ready_q      <= ready_d;
            code_q       <= code_d;
            an_n_q       <= an_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

`ifdef BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_on_q, blink_on_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_blink_q <= '0;
            disp_blink_q <= '0;
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
        end else begin
            pend_blink_q <= pend_blink_d;
            disp_blink_q <= disp_blink_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_done) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end
`endif

    // Buffer update: a pending frame is promoted only at the frame boundary, so
    // swap and accept are mutually exclusive (pending implies not ready).
    always_comb begin
        swap         = frame_done && pending_q;
        accept       = load && ready_q;
        pend_codes_d = pend_codes_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pending_d    = pending_q;
        disp_codes_d = disp_codes_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
`ifdef BLINK_EN
        pend_blink_d = pend_blink_q;
        disp_blink_d = disp_blink_q;
`endif
        if (swap) begin
            disp_codes_d = pend_codes_q;
            disp_dp_d    = pend_dp_q;
            disp_blank_d = pend_blank_q;
`ifdef BLINK_EN
            disp_blink_d = pend_blink_q;
`endif
            pending_d    = 1'b0;
        end else if (accept) begin
            pend_codes_d = codes_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
`ifdef BLINK_EN
            pend_blink_d = blink_in;
`endif
            pending_d    = 1'b1;
        end
        ready_d = ~pending_d;
    end

    // Outputs are computed from next-cycle timer state and buffer contents so the
    // registered values line up exactly with the slot they belong to. A dark digit
    // (blanked, or blinked off) also keeps its decimal point off.
    always_comb begin
        dark = disp_blank_d[idx_nx];
`ifdef BLINK_EN
        dark = dark | (disp_blink_d[idx_nx] & ~blink_on_d);
`endif
        code_d = BLANK_CODE;
        an_n_d = '1;
        dp_n_d = 1'b1;
        if (state_nx == S_DRIVE && !dark) begin
            code_d         = disp_codes_d[int'(idx_nx)*CODE_W +: CODE_W];
            an_n_d[idx_nx] = 1'b0;
            dp_n_d         = ~disp_dp_d[idx_nx];
        end
    end

    assign ready    = ready_q;
    assign code_out = code_q;
    assign an_n     = an_n_q;
    assign dp_n     = dp_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed frame loads, mid-frame reset and random
// loads compared every cycle against a slot-arithmetic reference model.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int DC = 10;
    localparam int GC = 2;
    localparam int FR = N * DC;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [N*CW-1:0]   codes_in = '0;
    logic [N-1:0]      dp_in = '0;
    logic [N-1:0]      blank_in = '0;
    logic              ready;
    logic [CW-1:0]     code_out;
    logic [N-1:0]      an_n;
    logic              dp_n;
    logic              frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .CODE_W     (CW),
        .CLK_HZ     (1000),
        .REFRESH_HZ (100),
        .GUARD_CYC  (GC),
        .BLANK_CODE (5'd31)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .codes_in   (codes_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
`ifdef BLINK_EN
        .blink_in   ('0),
`endif
        .ready      (ready),
        .code_out   (code_out),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;
    int m_code[N], m_dp[N], m_blank[N];
    int p_code[N], p_dp[N], p_blank[N];
    bit pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_code[k]  = 31;
            m_dp[k]    = 1;
            m_blank[k] = 1;
        end
        pending = 1'b0;
        t = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},    32'(an_n),       32'hF);
        chk({tag, "_code"},  32'(code_out),   32'd31);
        chk({tag, "_dp"},    32'(dp_n),       32'd1);
        chk({tag, "_ready"}, 32'(ready),      32'd1);
        chk({tag, "_fd"},    32'(frame_done), 32'd0);
    endtask

    // Expected display for cycle t: slot = which digit, pos = cycle within the slot.
    task automatic check_outputs();
        int slot, pos;
        logic [3:0] e_an;
        int e_code, e_dp;
        slot   = (t % FR) / DC;
        pos    = t % DC;
        e_an   = 4'hF;
        e_code = 31;
        e_dp   = 1;
        if (pos >= GC && m_blank[slot] == 0) begin
            e_an[slot] = 1'b0;
            e_code     = m_code[slot];
            e_dp       = (m_dp[slot] != 0) ? 0 : 1;
        end
        chk("an_n",       32'(an_n),       32'(e_an));
        chk("code_out",   32'(code_out),   32'(e_code));
        chk("dp_n",       32'(dp_n),       32'(e_dp));
        chk("ready",      32'(ready),      32'(!pending));
        chk("frame_done", 32'(frame_done), 32'((t % FR) == FR - 1));
    endtask

    task automatic do_cycle(input bit ld, input logic [N*CW-1:0] c,
                            input logic [N-1:0] d, input logic [N-1:0] b);
        check_outputs();
        load     = ld;
        codes_in = c;
        dp_in    = d;
        blank_in = b;
        if (ld) $display("t=%0d load codes=%h dp=%b blank=%b accepted=%0d", t, c, d, b, !pending);
        @(posedge clk);
        if ((t % FR) == FR - 1 && pending) begin
            m_code  = p_code;
            m_dp    = p_dp;
            m_blank = p_blank;
            pending = 1'b0;
        end else if (ld && !pending) begin
            for (int k = 0; k < N; k++) begin
                p_code[k]  = int'(c[k*CW +: CW]);
                p_dp[k]    = int'(d[k]);
                p_blank[k] = int'(b[k]);
            end
            pending = 1'b1;
        end
        t++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [N*CW-1:0] rc;
        logic [N-1:0]    rd, rb;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Frame {3,2,1,0} at t=5, ignored load at t=10, blanked-digit frame at t=45
        idle_cycles(5);
        do_cycle(1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 4'b0000);
        idle_cycles(4);
        do_cycle(1'b1, {5'd10, 5'd11, 5'd12, 5'd13}, 4'b1111, 4'b0000);
        idle_cycles(34);
        do_cycle(1'b1, {5'd21, 5'd20, 5'd19, 5'd18}, 4'b1010, 4'b0010);
        idle_cycles(79);
        do_cycle(1'b1, {5'd7, 5'd8, 5'd9, 5'd4}, 4'b0001, 4'b0000);
        idle_cycles(9);

        // Mid-frame asynchronous reset with a frame pending
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_cycles(100);

        // Random loads
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) rc[k*CW +: CW] = CW'($urandom_range(0, 21));
            rd = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            do_cycle($urandom_range(0, 7) == 0, rc, rd, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
